// File: rtl/dma_line_bridge.sv
// dma_line_bridge: host word port to Avalon-MM master with one line of
// read buffering, write-through, read-beat timeout and activity LED.
module dma_line_bridge #(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int LINE     = 8,
  parameter int TIMEOUT  = 4096,
  parameter int LED_HOLD = 4500000
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            dma_rd,
  input  logic            dma_wr,
  input  logic [AW-1:0]   dma_addr,
  input  logic [DW-1:0]   dma_dout,
  output logic [DW-1:0]   dma_din,
  output logic            ioctl_wait,
  input  logic            cache_inv,
  output logic            err,
  input  logic            err_clr,
  output logic            act_led,
  output logic [AW-1:0]   avm_address,
  output logic            avm_read,
  output logic            avm_write,
  output logic [DW-1:0]   avm_writedata,
  output logic [DW/8-1:0] avm_byteenable,
  output logic [7:0]      avm_burstcount,
  input  logic            avm_waitrequest,
  input  logic [DW-1:0]   avm_readdata,
  input  logic            avm_readdatavalid
);
  localparam int BW  = DW / 8;
  localparam int OFS = $clog2(BW);
  localparam int LW  = $clog2(LINE);
  localparam int TW  = AW - OFS - LW;
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam int LCW = $clog2(LED_HOLD + 2);

  typedef enum logic [1:0] {
    IDLE, RD_REQ, RD_DATA, WR_REQ
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   line_q [LINE];
  logic [DW-1:0]   line_d [LINE];
  logic [TW-1:0]   tag_q, tag_d;
  logic [TW-1:0]   rtag_q, rtag_d;
  logic [LW-1:0]   ridx_q, ridx_d;
  logic [LW-1:0]   beat_q, beat_d;
  logic            valid_q, valid_d;
  logic            inv_q, inv_d;
  logic            wait_q, wait_d;
  logic            err_q, err_d;
  logic [DW-1:0]   din_q, din_d;
  logic [TCW-1:0]  to_q, to_d;
  logic [LCW-1:0]  led_q, led_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [BW-1:0]   be_q, be_d;
  logic [7:0]      bc_q, bc_d;

  logic [TW-1:0]   in_tag;
  logic [LW-1:0]   in_idx;
  logic            hit;
  logic            unused_lsb;

  assign in_tag     = dma_addr[AW-1:OFS+LW];
  assign in_idx     = dma_addr[OFS+LW-1:OFS];
  assign hit        = valid_q && (tag_q == in_tag);
  assign unused_lsb = ^dma_addr[OFS-1:0];

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    tag_d   = tag_q;
    rtag_d  = rtag_q;
    ridx_d  = ridx_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    inv_d   = inv_q;
    wait_d  = wait_q;
    err_d   = err_q & ~err_clr;
    din_d   = din_q;
    to_d    = to_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    bc_d    = bc_q;
    unique case (state_q)
      IDLE: begin
        if (dma_wr) begin
          state_d = WR_REQ;
          wait_d  = 1'b1;
          wr_d    = 1'b1;
          bc_d    = 8'd1;
          be_d    = '1;
          wdata_d = dma_dout;
          addr_d  = {dma_addr[AW-1:OFS], {OFS{1'b0}}};
          if (hit) line_d[in_idx] = dma_dout;
        end else if (dma_rd) begin
          if (hit) begin
            din_d = line_q[in_idx];
          end else begin
            state_d = RD_REQ;
            wait_d  = 1'b1;
            rd_d    = 1'b1;
            bc_d    = 8'(LINE);
            addr_d  = {in_tag, {(OFS+LW){1'b0}}};
            rtag_d  = in_tag;
            ridx_d  = in_idx;
            inv_d   = 1'b0;
          end
        end
      end
      RD_REQ: begin
        if (!avm_waitrequest) begin
          rd_d    = 1'b0;
          state_d = RD_DATA;
          beat_d  = '0;
          to_d    = '0;
        end
      end
      RD_DATA: begin
        to_d = to_q + 1'b1;
        if (avm_readdatavalid) begin
          line_d[beat_q] = avm_readdata;
          beat_d = beat_q + 1'b1;
          to_d   = '0;
          if (beat_q == LW'(LINE-1)) begin
            tag_d   = rtag_q;
            valid_d = !inv_q;
            // requested word may be arriving right now
            din_d   = (ridx_q == LW'(LINE-1)) ?
                      avm_readdata : line_q[ridx_q];
            wait_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (to_q == TCW'(TIMEOUT-1)) begin
          err_d   = 1'b1;
          din_d   = '1;
          valid_d = 1'b0;
          wait_d  = 1'b0;
          state_d = IDLE;
        end
      end
      WR_REQ: begin
        if (!avm_waitrequest) begin
          wr_d    = 1'b0;
          be_d    = '0;
          wait_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // a line in flight still returns data but is never marked valid
    if (cache_inv) begin
      valid_d = 1'b0;
      if (state_q == RD_REQ || state_q == RD_DATA) inv_d = 1'b1;
    end
    if (wait_q) led_d = LCW'(LED_HOLD);
    else if (led_q != '0) led_d = led_q - 1'b1;
    else led_d = led_q;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      tag_q   <= '0;
      rtag_q  <= '0;
      ridx_q  <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      inv_q   <= 1'b0;
      wait_q  <= 1'b0;
      err_q   <= 1'b0;
      din_q   <= '0;
      to_q    <= '0;
      led_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      bc_q    <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      tag_q   <= tag_d;
      rtag_q  <= rtag_d;
      ridx_q  <= ridx_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      inv_q   <= inv_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      din_q   <= din_d;
      to_q    <= to_d;
      led_q   <= led_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      bc_q    <= bc_d;
    end
  end

  assign dma_din        = din_q;
  assign ioctl_wait     = wait_q;
  assign err            = err_q;
  assign act_led        = wait_q | (led_q != '0);
  assign avm_address    = addr_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = be_q;
  assign avm_burstcount = bc_q;
endmodule

// File: tb/tb_dma_line_bridge.sv
// tb_dma_line_bridge: scoreboard bench with an Avalon slave model and
// a line-cache reference model for dma_line_bridge.
module tb_dma_line_bridge;
  localparam int LINE = 8;
  localparam int LED_HOLD = 5;

  logic        clk_sys = 0;
  logic        reset, dma_rd, dma_wr, cache_inv, err_clr;
  logic [31:0] dma_addr, dma_dout, dma_din;
  logic        ioctl_wait, err, act_led;
  logic [31:0] avm_address, avm_writedata, avm_readdata;
  logic        avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
  logic [3:0]  avm_byteenable;
  logic [7:0]  avm_burstcount;

  dma_line_bridge #(.DW(32), .AW(32), .LINE(LINE), .TIMEOUT(16),
                    .LED_HOLD(LED_HOLD)) dut (
    .clk_sys(clk_sys), .reset(reset), .dma_rd(dma_rd), .dma_wr(dma_wr),
    .dma_addr(dma_addr), .dma_dout(dma_dout), .dma_din(dma_din),
    .ioctl_wait(ioctl_wait), .cache_inv(cache_inv), .err(err),
    .err_clr(err_clr), .act_led(act_led), .avm_address(avm_address),
    .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_burstcount(avm_burstcount), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid));

  always #5 clk_sys = ~clk_sys;

  typedef struct packed { logic [31:0] d; logic miss; } rsp_t;
  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;

  rsp_t        exp_q[$];
  wr_t         exp_wr_q[$];
  logic [31:0] exp_ra_q[$];
  int          tests = 0, fails = 0;
  bit          rd_out = 0, rd_first = 0;

  // reference model: plain memory plus one cached line
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] slv_mem [int unsigned];
  bit          m_valid = 0;
  int unsigned m_tag = 0;
  logic [31:0] m_line [LINE];

  // slave controls
  int hold_fixed = -1, beat_limit = LINE, stray_n = 0;
  int burst_left = 0, beats_sent = 0, gap = 0, hold = 0;
  bit req_seen = 0;
  logic [31:0] burst_w = 0;

  function automatic logic [31:0] defw(input int unsigned w);
    if ((w >> 3) == 32'h80) return 32'hA0 + (w & 7);
    return w * 32'h9E3779B1;
  endfunction
  function automatic logic [31:0] ref_word(input int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : defw(w);
  endfunction
  function automatic logic [31:0] slv_word(input int unsigned w);
    return slv_mem.exists(w) ? slv_mem[w] : defw(w);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Avalon slave
  initial begin
    avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = 0;
    forever begin
      @(negedge clk_sys);
      avm_readdatavalid = 0;
      if (stray_n > 0) begin
        avm_readdatavalid = 1; avm_readdata = $urandom; stray_n--;
      end else if (burst_left > 0) begin
        if (beats_sent >= beat_limit) burst_left = 0;
        else if (gap >= 2 || $urandom_range(0, 3) != 0) begin
          avm_readdatavalid = 1;
          avm_readdata = slv_word(burst_w + beats_sent);
          beats_sent++; burst_left--; gap = 0;
        end else gap++;
      end
      if (avm_read || avm_write) begin
        if (!req_seen) begin
          req_seen = 1;
          hold = (hold_fixed >= 0) ? hold_fixed : $urandom_range(0, 2);
        end
        if (hold > 0) begin
          avm_waitrequest = 1; hold--;
        end else begin
          avm_waitrequest = 0; req_seen = 0;
          if (avm_read) begin
            burst_left = int'(avm_burstcount);
            burst_w = avm_address >> 2; beats_sent = 0; gap = 0;
          end
          if (avm_write) slv_mem[avm_address >> 2] = avm_writedata;
        end
      end else begin
        avm_waitrequest = 1'($urandom_range(0, 1)); req_seen = 0;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    rsp_t r; wr_t w; logic [31:0] a;
    forever begin
      @(negedge clk_sys); #2;
      if (!reset) begin
        if (avm_read && avm_write) chk("rd_wr_excl", 1, 0);
        if (avm_read && !avm_waitrequest) begin
          if (exp_ra_q.size() == 0) chk("unexp_rd", 1, 0);
          else begin
            a = exp_ra_q.pop_front();
            chk("rd_addr", avm_address, a);
            chk("rd_bc", avm_burstcount, LINE);
          end
        end
        if (avm_write && !avm_waitrequest) begin
          if (exp_wr_q.size() == 0) chk("unexp_wr", 1, 0);
          else begin
            w = exp_wr_q.pop_front();
            chk("wr_addr", avm_address, w.a);
            chk("wr_data", avm_writedata, w.d);
            chk("wr_be_bc", {avm_byteenable, avm_burstcount}, {4'hF, 8'd1});
          end
        end
        if (rd_out && exp_q.size() > 0) begin
          if (rd_first) begin
            chk("rd_wait", ioctl_wait, exp_q[0].miss); rd_first = 0;
          end
          if (!ioctl_wait) begin
            r = exp_q.pop_front();
            chk("rd_data", dma_din, r.d);
            rd_out = 0;
          end
        end
      end
    end
  end

  task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d);
    @(negedge clk_sys);
    dma_rd = rd; dma_wr = wr; dma_addr = a; dma_dout = d;
    @(negedge clk_sys);
    dma_rd = 0; dma_wr = 0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin @(negedge clk_sys); #3; n++; end
    while ((ioctl_wait || rd_out) && n < 300);
    tests++;
    if (ioctl_wait || rd_out) begin
      fails++;
      $display("FAIL %s: still busy after %0d cycles", nm, n);
      rd_out = 0; exp_q.delete();
    end
  endtask

  task automatic do_rd(input logic [31:0] a, input bit tmo,
                       input bit wait_done);
    int unsigned w, tg;
    rsp_t r;
    w = a >> 2; tg = w >> 3;
    if (m_valid && m_tag == tg) begin
      r.d = m_line[w & 7]; r.miss = 0;
    end else begin
      r.miss = 1;
      exp_ra_q.push_back(a & 32'hFFFF_FFE0);
      if (tmo) begin
        r.d = '1; m_valid = 0;
      end else begin
        for (int i = 0; i < LINE; i++) m_line[i] = ref_word(tg * 8 + i);
        m_valid = 1; m_tag = tg; r.d = m_line[w & 7];
      end
    end
    exp_q.push_back(r);
    issue(1, 0, a, 0);
    rd_out = 1; rd_first = 1;
    if (wait_done) wait_idle("rd_done");
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [31:0] d,
                       input bit with_rd, output int hi, output bit w1);
    int unsigned w;
    wr_t e;
    w = a >> 2;
    ref_mem[w] = d;
    if (m_valid && m_tag == (w >> 3)) m_line[w & 7] = d;
    e.a = a & 32'hFFFF_FFFC; e.d = d;
    exp_wr_q.push_back(e);
    issue(with_rd, 1, a, d);
    hi = 0; #3; w1 = ioctl_wait;
    for (int n = 0; n < 300 && ioctl_wait; n++) begin
      if (avm_write) hi++;
      @(negedge clk_sys); #3;
    end
    tests++;
    if (ioctl_wait) begin
      fails++; $display("FAIL wr_done: still busy");
    end
  endtask

  task automatic wait_beats(input int nb);
    int n = 0;
    while (!(burst_left > 0 && beats_sent >= nb) && n < 200) begin
      @(negedge clk_sys); #1; n++;
    end
    tests++;
    if (n >= 200) begin fails++; $display("FAIL wait_beats: none"); end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hi, n; bit w1;
    logic [31:0] a;
    int op;
    reset = 1; dma_rd = 0; dma_wr = 0; cache_inv = 0; err_clr = 0;
    dma_addr = 0; dma_dout = 0;
    repeat (3) @(negedge clk_sys);
    #3;
    chk("rst_out", {ioctl_wait, avm_read, avm_write, err, act_led}, 0);
    chk("rst_din", dma_din, 0);
    reset = 0;

    // read miss then hit
    do_rd(32'h1004, 0, 1);
    chk("miss_din", dma_din, 32'hA1);
    do_rd(32'h101C, 0, 1);
    chk("hit_din", dma_din, 32'hA7);

    // write-through with held waitrequest, then LED stretch
    hold_fixed = 3;
    do_wr(32'h1008, 32'h55, 0, hi, w1);
    hold_fixed = -1;
    chk("wr_wait1", w1, 1);
    chk("wr_hold", hi, 4);
    n = 0;
    while (act_led && n < 50) begin n++; @(negedge clk_sys); #3; end
    chk("led_hold", n, LED_HOLD);
    do_rd(32'h1008, 0, 1);
    chk("wt_hit", dma_din, 32'h55);

    // stray beats while idle leave the line intact
    stray_n = 3;
    repeat (5) @(negedge clk_sys);
    do_rd(32'h1014, 0, 1);

    // timeout
    beat_limit = 3;
    do_rd(32'h2004, 1, 1);
    beat_limit = LINE;
    chk("tmo_err", err, 1);
    chk("tmo_din", dma_din, 32'hFFFF_FFFF);
    do_rd(32'h2004, 0, 1);
    @(negedge clk_sys); err_clr = 1;
    @(negedge clk_sys); err_clr = 0; #3;
    chk("err_clr", err, 0);

    // rd+wr collision: write wins
    do_wr(32'h100C, 32'hDEAD_BEEF, 1, hi, w1);
    do_rd(32'h100C, 0, 1);

    // invalidate during RD_DATA
    do_rd(32'h5010, 0, 0);
    wait_beats(2);
    cache_inv = 1;
    @(negedge clk_sys); #1; cache_inv = 0;
    m_valid = 0;
    wait_idle("inv_rd");
    do_rd(32'h5010, 0, 1);

    // reset mid-burst
    do_rd(32'h3004, 0, 0);
    wait_beats(4);
    reset = 1; rd_out = 0; exp_q.delete(); m_valid = 0;
    @(negedge clk_sys); #1; reset = 0;
    chk("mid_rst_out", {ioctl_wait, avm_read, avm_write, err}, 0);
    chk("mid_rst_din", dma_din, 0);
    n = 0;
    while (burst_left > 0 && n < 100) begin @(negedge clk_sys); n++; end
    do_rd(32'h3004, 0, 1);

    // randomized traffic over four lines
    for (int k = 0; k < 80; k++) begin
      a = 32'h6000 + ($urandom_range(0, 3) << 5) +
          ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      op = $urandom_range(0, 19);
      if (op < 13) do_rd(a, 0, 1);
      else if (op < 19) do_wr(a, $urandom, 0, hi, w1);
      else begin
        @(negedge clk_sys); cache_inv = 1;
        @(negedge clk_sys); cache_inv = 0;
        m_valid = 0;
      end
    end
    repeat (4) @(negedge clk_sys);
    chk("exp_left", exp_q.size() + exp_wr_q.size() + exp_ra_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
